// File: rtl/mac_seq.sv
// Job sequencer in front of the non-pipelined INT8/FP16 MAC: clears, configures, streams operand pairs, reads back the result.
// Optional idle-beat watchdog in LOAD is compiled in with MAC_SEQ_TIMEOUT_EN.
module mac_seq #(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_start,
  input  logic             job_mode,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_error,
  output logic             mac_clr_n,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error
);

  // Both ports use valid/ready: a transfer happens on the rising edge where valid and ready are both high.
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_CFG, S_LOAD, S_READ, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_error_q, res_error_d;
  logic             mac_clr_n_q, mac_clr_n_d;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]  idle_q, idle_d;
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    job_busy    = (state_q != S_IDLE);
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    mac_enable  = 1'b0;
    mac_valid   = 1'b0;
    mac_read    = 1'b0;
    mac_cfg     = 1'b0;
    mac_mode    = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
`ifdef MAC_SEQ_TIMEOUT_EN
    idle_d      = idle_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          mode_d  = job_mode;
          len_d   = job_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_CFG;
      S_CFG: begin
        mac_cfg  = 1'b1;
        mac_mode = mode_q;
        state_d  = (len_q == '0) ? S_READ : S_LOAD;
`ifdef MAC_SEQ_TIMEOUT_EN
        idle_d   = '0;
`endif
      end
      S_LOAD: begin
        mac_enable = 1'b1;
        op_ready   = 1'b1;
        mac_valid  = op_valid;
        mac_a      = op_a;
        mac_b      = op_b;
        if (op_valid) begin
          // len_q is at least 1 here, so the counter never wraps past len_q
          cnt_d = cnt_q + LEN_W'(1);
          err_d = err_q | mac_error;
          if (cnt_d == len_q) state_d = S_READ;
`ifdef MAC_SEQ_TIMEOUT_EN
          idle_d = '0;
        end else begin
          idle_d = idle_q + TO_W'(1);
          if (idle_d == TO_W'(TIMEOUT_CYC)) begin
            state_d     = S_RESP;
            res_data_d  = '0;
            res_error_d = 1'b1;
          end
`endif
        end
      end
      S_READ: begin
        mac_enable  = 1'b1;
        mac_read    = 1'b1;
        res_data_d  = mac_out;
        res_error_d = err_q | mac_error;
        state_d     = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so the clear is a clean full-cycle pulse aligned with CLR.
    mac_clr_n_d = (state_d != S_CLR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      mac_clr_n_q <= 1'b1;
`ifdef MAC_SEQ_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      mac_clr_n_q <= mac_clr_n_d;
`ifdef MAC_SEQ_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign res_data  = res_data_q;
  assign res_error = res_error_q;
  assign mac_clr_n = mac_clr_n_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: behavioural MAC attached to the mac_* port, randomized jobs, scoreboard of expected results.
// Define MAC_SEQ_TIMEOUT_EN to build the watchdog variant (TIMEOUT_CYC = 8) and run its test.
module tb_mac_seq;
  localparam int LEN_W = 8;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic clk, rst_n;
  logic job_start, job_mode, job_busy;
  logic [LEN_W-1:0] job_len;
  logic op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic res_valid, res_ready, res_error;
  logic [15:0] res_data;
  logic mac_clr_n, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode, mac_error;
  logic [15:0] mac_a, mac_b, mac_out;

  mac_seq #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_start(job_start), .job_mode(job_mode), .job_len(job_len), .job_busy(job_busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .mac_clr_n(mac_clr_n), .mac_enable(mac_enable), .mac_valid(mac_valid), .mac_read(mac_read),
    .mac_cfg(mac_cfg), .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out), .mac_error(mac_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int clr_cnt = 0, cfg_cnt = 0, valid_cnt = 0;
  logic cur_mode = 1'b0;
  int hold_low = 0;
  bit rdy_rand = 0;
  logic [16:0] exp_q[$];
  int lat_q[$];
  logic [15:0] pa[$], pb[$];
  bit pe[$];
  logic [15:0] fp_tab [8] = '{16'h0000, 16'h3800, 16'h3C00, 16'h3E00, 16'h4000, 16'h4100, 16'h4200, 16'h4400};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- arithmetic helpers ----------------
  // fp16 values are handled as fixed point scaled by 1024; stimulus keeps them exact.
  function automatic longint fp_fix(input logic [15:0] h);
    int e;
    longint m;
    e = int'(h[14:10]);
    if (e == 0) return 0;
    m = 1024 + longint'(h[9:0]);
    if (e >= 15) return m <<< (e - 15);
    return m >>> (15 - e);
  endfunction

  function automatic logic [15:0] fix_fp(input longint v);
    int p;
    logic [15:0] r;
    if (v <= 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 40; i++) if (v[i]) p = i;
    r[15]    = 1'b0;
    r[14:10] = 5'(p + 5);
    r[9:0]   = (p >= 10) ? 10'(v >> (p - 10)) : 10'(v << (10 - p));
    return r;
  endfunction

  function automatic longint prod(input logic mode, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb;
    if (mode) return (fp_fix(a) * fp_fix(b)) >>> 10;
    sa = $signed(a[7:0]);
    sb = $signed(b[7:0]);
    return sa * sb;
  endfunction

  function automatic logic [15:0] fmt(input logic mode, input longint v);
    if (mode) return fix_fp(v);
    return 16'(v);
  endfunction

  // ---------------- behavioural MAC ----------------
  wire mac_rst_n = mac_clr_n & rst_n;
  logic [15:0] ma_q, mb_q;
  logic mm_q;
  longint macc_q;
  always @(posedge clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      ma_q <= '0; mb_q <= '0; mm_q <= 1'b0; macc_q <= 0;
    end else if (!mac_enable && mac_cfg) begin
      mm_q <= mac_mode;
    end else if (mac_enable && mac_valid) begin
      macc_q <= macc_q + prod(mm_q, ma_q, mb_q);
      ma_q   <= mac_a;
      mb_q   <= mac_b;
    end
  end
  assign mac_out = (mac_read && mac_enable && !mac_valid) ? fmt(mm_q, macc_q + prod(mm_q, ma_q, mb_q)) : 16'h0000;

  // ---------------- result consumer ----------------
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_low > 0) begin
        res_ready = 1'b0;
        if (res_valid) hold_low--;
      end else begin
        res_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_v = 1'b0;
  logic [16:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (!mac_clr_n) clr_cnt++;
      if (mac_cfg) begin
        cfg_cnt++;
        check("cfg_enable_mode", {mac_enable, mac_mode}, {1'b0, cur_mode});
      end
      if (mac_enable && mac_valid) valid_cnt++;
      if (res_valid && !prev_v) begin
        held = {res_error, res_data};
        if (lat_q.size() > 0 && lat_q[0] >= 0) check("latency", cyc, lat_q[0]);
      end else if (res_valid) begin
        check("res_stable", {res_error, res_data}, held);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", exp_q.size(), 1);
        end else begin
          check("res_data", res_data, exp_q[0][15:0]);
          check("res_error", res_error, exp_q[0][16]);
          exp_q.pop_front();
          if (lat_q.size() > 0) lat_q.pop_front();
        end
      end
      prev_v = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string name);
    check({name, "_ctl"}, {job_busy, op_ready, res_valid, res_error, mac_clr_n,
                           mac_enable, mac_valid, mac_read, mac_cfg, mac_mode}, 10'b0000100000);
    check({name, "_data"}, {res_data, mac_a}, 32'h0);
    check({name, "_mac_b"}, mac_b, 16'h0);
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin step(); w++; end
    check(name, exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete(); lat_q.delete();
      rst_n = 1'b0; step(); rst_n = 1'b1;
    end
    step();
  endtask

  task automatic fill_rand(input logic mode, input int n, input int err_pct);
    logic [7:0] a8, b8;
    pa.delete(); pb.delete(); pe.delete();
    for (int k = 0; k < n; k++) begin
      if (mode) begin
        pa.push_back(fp_tab[$urandom_range(0, 7)]);
        pb.push_back(fp_tab[$urandom_range(0, 7)]);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        pa.push_back({{8{a8[7]}}, a8});
        pb.push_back({{8{b8[7]}}, b8});
      end
      pe.push_back($urandom_range(0, 99) < err_pct);
    end
  endtask

  // Runs one job from the pairs in pa/pb/pe; want >= 0 overrides the model with a fixed {error,data}.
  task automatic run_job(input logic mode, input int gmin, input int gmax, input bit chk_lat,
                         input bit poke, input int want);
    int n, c0, f0, v0, w, g;
    longint sum;
    logic any_err;
    logic [16:0] e;
    n = pa.size();
    cur_mode = mode;
    c0 = clr_cnt; f0 = cfg_cnt; v0 = valid_cnt;
    sum = 0; any_err = 1'b0;
    for (int k = 0; k < n; k++) begin
      sum += prod(mode, pa[k], pb[k]);
      any_err |= pe[k];
    end
    e = (want >= 0) ? 17'(want) : {any_err, fmt(mode, sum)};
    job_start = 1'b1; job_mode = mode; job_len = LEN_W'(n);
    step();
    job_start = 1'b0;
    exp_q.push_back(e);
    lat_q.push_back(chk_lat ? cyc + n + 3 : -1);
    for (int k = 0; k < n; k++) begin
      op_valid = 1'b1; op_a = pa[k]; op_b = pb[k]; mac_error = pe[k];
      w = 0;
      while (!op_ready && w < 200) begin step(); w++; end
      if (w >= 200) begin
        check("op_ready_wait", op_ready, 1);
        break;
      end
      step();
      op_valid = 1'b0; mac_error = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
      g = $urandom_range(gmin, gmax);
      for (int j = 0; j < g; j++) begin
        if (poke && k == 0 && j == 0) begin
          job_start = 1'b1; job_len = 8'd77; job_mode = ~mode;
        end
        step();
        job_start = 1'b0;
      end
    end
    wait_done("job_done");
    check("clr_pulses", clr_cnt - c0, 1);
    check("cfg_pulses", cfg_cnt - f0, 1);
    check("valid_pulses", valid_cnt - v0, n);
    check("busy_after", job_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    rst_n = 1'b0; job_start = 1'b0; job_mode = 1'b0; job_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; mac_error = 1'b0;
    repeat (3) step();
    chk_reset("reset_hold");
    rst_n = 1'b1;
    step(); step();
    chk_reset("reset_idle");

    // int8 dot product, gapless, latency N+3
    pa = '{16'd2, 16'd4, 16'd1}; pb = '{16'd3, 16'd5, 16'd7}; pe = '{0, 0, 0};
    run_job(1'b0, 0, 0, 1, 0, 17'h00021);

    // fp16: 1*2 + 1.5*2 = 5.0
    pa = '{16'h3C00, 16'h3E00}; pb = '{16'h4000, 16'h4000}; pe = '{0, 0};
    run_job(1'b1, 0, 0, 1, 0, 17'h04500);

    // back-to-back jobs; accumulator must be cleared in between
    pa = '{16'd5}; pb = '{16'd5}; pe = '{0};
    run_job(1'b0, 0, 0, 1, 0, 17'h00019);
    pa = '{16'd2}; pb = '{16'd2}; pe = '{0};
    run_job(1'b0, 0, 0, 1, 0, 17'h00004);

    // 2-cycle gaps, consumer stalled 4 cycles, stray job_start while loading
    hold_low = 4;
    pa = '{16'd2, 16'd4, 16'd1}; pb = '{16'd3, 16'd5, 16'd7}; pe = '{0, 0, 0};
    run_job(1'b0, 2, 2, 0, 1, 17'h00021);

    // empty job
    pa.delete(); pb.delete(); pe.delete();
    run_job(1'b0, 0, 0, 1, 0, 17'h00000);

    // MAC error on one beat
    pa = '{16'd1, 16'd1, 16'd1}; pb = '{16'd1, 16'd1, 16'd1}; pe = '{0, 1, 0};
    run_job(1'b0, 0, 0, 1, 0, 17'h10003);

    // operands offered in IDLE are not taken
    w = valid_cnt;
    op_valid = 1'b1; op_a = 16'd9; op_b = 16'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_op_ready", {op_ready, mac_valid}, 2'b00);
    end
    op_valid = 1'b0;
    check("idle_no_beats", valid_cnt - w, 0);

    // reset in the middle of LOAD
    cur_mode = 1'b0;
    job_start = 1'b1; job_mode = 1'b0; job_len = 8'd5;
    step();
    job_start = 1'b0;
    op_valid = 1'b1; op_a = 16'd3; op_b = 16'd3;
    w = 0;
    while (!op_ready && w < 20) begin step(); w++; end
    step(); step();
    check("mid_load_busy", job_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_load");
    op_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // full-length job: counter must reach 2^LEN_W-1 without wrapping
    fill_rand(1'b0, 255, 0);
    run_job(1'b0, 0, 0, 1, 0, -1);

`ifdef MAC_SEQ_TIMEOUT_EN
    // one beat then silence: watchdog ends the job with an error and zero data
    cur_mode = 1'b0;
    job_start = 1'b1; job_mode = 1'b0; job_len = 8'd2;
    step();
    job_start = 1'b0;
    exp_q.push_back(17'h10000);
    lat_q.push_back(cyc + 11);
    op_valid = 1'b1; op_a = 16'd3; op_b = 16'd3;
    w = 0;
    while (!op_ready && w < 20) begin step(); w++; end
    step();
    op_valid = 1'b0;
    wait_done("timeout_done");
`endif

    // randomized jobs
    rdy_rand = 1;
    for (int j = 0; j < 40; j++) begin
      logic m;
      int n, gm;
      m  = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 10);
      gm = $urandom_range(0, 3);
      fill_rand(m, n, 10);
      run_job(m, 0, gm, gm == 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Job sequencer directly upstream of the non-pipelined 16-bit INT8/FP16 MAC (mac_top).
- Accepts a job descriptor (mode, length), streams operand pairs in over a valid/ready handshake, and generates the MAC's cfg/enable/valid/read protocol.
- Clears the MAC accumulator between jobs, captures the dot-product result and returns it over a valid/ready result port.

Parameters:
- LEN_W, 8: width of job length field; max job = 2^LEN_W-1 pairs.
- TIMEOUT_CYC, 255: idle-beat watchdog limit; used only with MAC_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- job_start  in  1  one-cycle job request; sampled only in IDLE.
- job_mode  in  1  1: fp16, 0: int8; sampled with job_start.
- job_len  in  LEN_W  number of operand pairs; sampled with job_start.
- job_busy  out  1  high in every state except IDLE.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer accepts the pair.
- op_a  in  16  operand A.
- op_b  in  16  operand B.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  16  accumulated result.
- res_error  out  1  sticky MAC error or abort for this job.
- mac_clr_n  out  1  registered active-low accumulator clear, integrated as mac rst_n AND rst_n.
- mac_enable  out  1  to MAC enable.
- mac_valid  out  1  to MAC valid.
- mac_read  out  1  to MAC read.
- mac_cfg  out  1  to MAC cfg.
- mac_mode  out  1  to MAC mode.
- mac_a  out  16  to MAC in_a.
- mac_b  out  16  to MAC in_b.
- mac_out  in  16  MAC result, combinational; nonzero only when read&enable&~valid.
- mac_error  in  1  MAC error flag.

Behaviour:
- Reset values: all outputs 0 except mac_clr_n=1; FSM in IDLE; counters 0.
- MAC contract:
  - Mode is latched when enable=0 and cfg=1.
  - On enable&valid the MAC loads a/b and sets acc <= a*b+acc.
  - mac_out = a*b+acc is readable when enable=1, valid=0, read=1.
  - Clear zeroes a, b, acc and mode.
- FSM states IDLE, CLR, CFG, LOAD, READ, RESP.
- IDLE:
  - All mac_* controls 0.
  - job_start=1 latches mode/len, clears the beat counter and sticky error, then goes to CLR.
- CLR, one cycle: mac_clr_n=0, enable=0. Next state CFG.
- CFG, one cycle: mac_cfg=1, mac_mode=latched mode, enable=0. Next state LOAD, or READ if len==0.
- LOAD:
  - mac_enable=1.
  - op_ready=1; mac_valid=op_valid; mac_a/mac_b driven combinationally from op_a/op_b.
  - Each beat (op_valid&op_ready) increments the counter and ORs mac_error into the sticky error.
  - Cycles with op_valid=0 hold state with mac_valid=0.
  - The beat that makes the counter equal len goes to READ; op_ready is still 1 on that beat.
- READ, one cycle:
  - enable=1, valid=0, read=1; op_ready=0.
  - Registers res_data<=mac_out and res_error<=sticky|mac_error. Next state RESP.
- RESP:
  - res_valid=1; res_data and res_error held stable.
  - res_valid&res_ready returns to IDLE and drops res_valid in the same edge.
- Latency:
  - Job with N pairs and no stalls: job_start edge to res_valid = N+3 cycles.
  - len=0: result 0 after 3 cycles.
- Boundaries:
  - job_start outside IDLE is ignored.
  - op_valid outside LOAD is never accepted.
  - len = 2^LEN_W-1 must not overflow the counter; counter width is LEN_W.
- Reset mid-job: immediate return to IDLE with reset values; the MAC is also reset through rst_n.
- No combinational path from res_ready to op_ready.

Optional Feature:
- Macro MAC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter in LOAD counts consecutive cycles without a beat and resets on each beat.
  - When it reaches TIMEOUT_CYC, FSM goes to RESP with res_data=0 and res_error=1, skipping READ; MAC controls drop to 0.
- Undefined: no counter exists; LOAD waits indefinitely.

Test Plan:
- int8, len=3, pairs (2,3),(4,5),(1,7) with op_valid held high -> res_data=16'h0021, res_error=0; res_valid 6 cycles after job_start.
- fp16, len=2, pairs (3C00,4000),(3E00,4000) -> mac_cfg pulse with mac_mode=1 in CFG; res_data=16'h4500.
- Back-to-back jobs: int8 len=1 (5,5) then len=1 (2,2) -> results 16'h0019 then 16'h0004; mac_clr_n pulses low once per job.
- len=3 with op_valid gaps of 2 cycles between beats, and res_ready held low for 4 cycles -> same result as gapless; res_data stable while res_valid=1; exactly 3 mac_valid pulses.
- len=0 -> res_data=0 after 3 cycles. job_start during LOAD -> ignored. rst_n low mid-LOAD -> all outputs at reset values, job_busy=0.
- MAC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, len=2, one beat then op_valid low -> after 8 idle cycles res_valid=1, res_error=1, res_data=0. Forced mac_error=1 on one beat -> res_error=1.
